// File: rtl/count_display_driver_pkg.sv
// Shared types and constants for the people-count 4-digit 7-segment display driver.
package count_display_driver_pkg;

  localparam int unsigned BIN_W     = 14;
  localparam int unsigned DIGITS    = 4;
  localparam int unsigned BCD_W     = 4 * DIGITS;
  localparam int unsigned MAX_COUNT = 9999;

  localparam logic [BIN_W-1:0] MAX_COUNT_BIN = BIN_W'(MAX_COUNT);

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } conv_state_e;

  // Active-high segment codes, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_ZERO  = 7'b0111111;
  localparam logic [6:0] SEG_DASH  = 7'b1000000;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  function automatic logic [6:0] seg_decode(input logic [3:0] digit);
    logic [6:0] code;
    case (digit)
      4'd0:    code = SEG_ZERO;
      4'd1:    code = 7'b0000110;
      4'd2:    code = 7'b1011011;
      4'd3:    code = 7'b1001111;
      4'd4:    code = 7'b1100110;
      4'd5:    code = 7'b1101101;
      4'd6:    code = 7'b1111101;
      4'd7:    code = 7'b0000111;
      4'd8:    code = 7'b1111111;
      4'd9:    code = 7'b1101111;
      default: code = SEG_BLANK;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter with a one-deep, last-value-wins pending slot.
module bin2bcd_seq
  import count_display_driver_pkg::*;
(
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [BIN_W-1:0] count_i,
  input  logic             valid_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [BCD_W-1:0] bcd_o,
  output logic             ovf_o
);

  localparam logic [3:0] CntLast = 4'(BIN_W - 1);

  conv_state_e      state_q, state_d;
  logic [BIN_W-1:0] bin_q, bin_d;
  logic [BCD_W-1:0] bcd_q, bcd_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             rng_q, rng_d;
  logic [BIN_W-1:0] pend_q, pend_d;
  logic             pend_vld_q, pend_vld_d;
  logic [BCD_W-1:0] adj;
  logic [BIN_W-1:0] load_val;

  always_comb begin
    state_d    = state_q;
    bin_d      = bin_q;
    bcd_d      = bcd_q;
    cnt_d      = cnt_q;
    rng_d      = rng_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;

    adj = bcd_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    // A strobe in DONE is newer than anything already pending
    load_val = valid_i ? count_i : pend_q;

    unique case (state_q)
      StIdle: begin
        if (valid_i) begin
          bin_d   = load_val;
          bcd_d   = '0;
          cnt_d   = '0;
          rng_d   = (load_val > MAX_COUNT_BIN);
          state_d = StShift;
        end
      end
      StShift: begin
        {bcd_d, bin_d} = {adj, bin_q} << 1;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == CntLast) state_d = StDone;
        if (valid_i) begin
          pend_d     = count_i;
          pend_vld_d = 1'b1;
        end
      end
      StDone: begin
        if (valid_i || pend_vld_q) begin
          bin_d      = load_val;
          bcd_d      = '0;
          cnt_d      = '0;
          rng_d      = (load_val > MAX_COUNT_BIN);
          pend_vld_d = 1'b0;
          state_d    = StShift;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= StIdle;
      bin_q      <= '0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      rng_q      <= 1'b0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bin_q      <= bin_d;
      bcd_q      <= bcd_d;
      cnt_q      <= cnt_d;
      rng_q      <= rng_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
    end
  end

  assign busy_o = (state_q != StIdle);
  assign done_o = (state_q == StDone);
  assign bcd_o  = bcd_q;
  assign ovf_o  = rng_q;

endmodule

// File: rtl/count_display_driver.sv
// Top level: conversion sub-module, display register, digit scan, blanking and output polarity.
module count_display_driver
  import count_display_driver_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 50000,
  parameter bit          BLANK_LZ    = 1'b1,
  parameter bit          ACTIVE_LOW  = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [BIN_W-1:0] count_in,
  input  logic             count_valid,
  output logic             busy,
  output logic             ovf,
  output logic [6:0]       seg,
  output logic             dp,
  output logic [3:0]       an
);

  localparam int unsigned CntW   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(REFRESH_DIV - 1);
  localparam logic [6:0] SegRst  = ACTIVE_LOW ? ~SEG_ZERO : SEG_ZERO;
  localparam logic [3:0] AnRst   = ACTIVE_LOW ? 4'b1110 : 4'b0001;
  localparam logic       DpOff   = ACTIVE_LOW;

  logic             conv_done;
  logic             conv_ovf;
  logic [BCD_W-1:0] conv_bcd;

  logic [BCD_W-1:0] disp_q, disp_d;
  logic             dovf_q, dovf_d;
  logic [CntW-1:0]  ref_q, ref_d;
  logic [1:0]       dig_q, dig_d;
  logic [6:0]       seg_q, seg_d;
  logic [3:0]       an_q, an_d;
  logic             ovf_q, ovf_d;

  logic [3:0]        nib;
  logic [DIGITS-1:0] lz;
  logic              run_zero;
  logic [6:0]        pat;

  bin2bcd_seq u_bin2bcd_seq (
    .clk_i   (clk),
    .reset_i (reset),
    .count_i (count_in),
    .valid_i (count_valid),
    .busy_o  (busy),
    .done_o  (conv_done),
    .bcd_o   (conv_bcd),
    .ovf_o   (conv_ovf)
  );

  always_comb begin
    disp_d = disp_q;
    dovf_d = dovf_q;
    if (conv_done) begin
      disp_d = conv_bcd;
      dovf_d = conv_ovf;
    end

    ref_d = ref_q + 1'b1;
    dig_d = dig_q;
    if (ref_q == CntMax) begin
      ref_d = '0;
      dig_d = dig_q + 2'd1;
    end

    nib = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (dig_q == 2'(i)) nib = disp_q[4*i +: 4];
    end

    // lz[i]: digit i and every higher digit are zero
    lz       = '0;
    run_zero = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      run_zero = run_zero & (disp_q[4*i +: 4] == 4'd0);
      lz[i]    = run_zero;
    end

    if (dovf_q) begin
      pat = SEG_DASH;
    end else if (BLANK_LZ && (dig_q != 2'd0) && lz[dig_q]) begin
      pat = SEG_BLANK;
    end else begin
      pat = seg_decode(nib);
    end

    seg_d = ACTIVE_LOW ? ~pat : pat;
    an_d  = ACTIVE_LOW ? ~(4'b0001 << dig_q) : (4'b0001 << dig_q);
    ovf_d = dovf_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      disp_q <= '0;
      dovf_q <= 1'b0;
      ref_q  <= '0;
      dig_q  <= '0;
      seg_q  <= SegRst;
      an_q   <= AnRst;
      ovf_q  <= 1'b0;
    end else begin
      disp_q <= disp_d;
      dovf_q <= dovf_d;
      ref_q  <= ref_d;
      dig_q  <= dig_d;
      seg_q  <= seg_d;
      an_q   <= an_d;
      ovf_q  <= ovf_d;
    end
  end

  assign seg = seg_q;
  assign an  = an_q;
  assign dp  = DpOff;
  assign ovf = ovf_q;

endmodule

// File: tb/tb_count_display_driver.sv
// Self-checking bench: directed scenarios plus random strobes against a cycle-level display model.
module tb_count_display_driver;

  logic        clk = 1'b0;
  logic        reset;
  logic [13:0] count_in;
  logic        count_valid;
  logic        busy, ovf, dp;
  logic [6:0]  seg;
  logic [3:0]  an;

  int tests = 0;
  int fails = 0;

  // Model state: cycle counter (incremented after each edge), display value,
  // busy window, scheduled display changes and the pending booking.
  int cyc = 0;
  int exp_val = 0;
  int busy_end = -100;
  int done_at = -100;
  int pend_start = -100;
  bit pend_open = 1'b0;
  int q_cyc[$];
  int q_val[$];

  logic [6:0] seg_tab [10] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
                               7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111};

  count_display_driver #(
    .REFRESH_DIV (4),
    .BLANK_LZ    (1'b1),
    .ACTIVE_LOW  (1'b1)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .count_in    (count_in),
    .count_valid (count_valid),
    .busy        (busy),
    .ovf         (ovf),
    .seg         (seg),
    .dp          (dp),
    .an          (an)
  );

  always #5 clk = ~clk;

  function automatic int an_index(input logic [3:0] a);
    case (a)
      4'b1110: return 0;
      4'b1101: return 1;
      4'b1011: return 2;
      4'b0111: return 3;
      default: return -1;
    endcase
  endfunction

  // Expected active-low segment drive for decimal value v on digit d
  function automatic logic [6:0] model_seg(input int v, input int d);
    int p;
    logic [6:0] hi;
    p = 1;
    for (int i = 0; i < d; i++) p = p * 10;
    if (v > 9999) hi = 7'b1000000;
    else if (d != 0 && v < p) hi = 7'b0000000;
    else hi = seg_tab[(v / p) % 10];
    return ~hi;
  endfunction

  task automatic check_outputs();
    int d;
    logic exp_busy;
    logic exp_ovf;
    logic [6:0] exp_seg;
    exp_busy = (cyc <= busy_end);
    exp_ovf  = (exp_val > 9999);
    tests++;
    assert (busy === exp_busy) else begin
      fails++;
      $error("FAIL busy cyc=%0d got %b expected %b", cyc, busy, exp_busy);
    end
    tests++;
    assert (ovf === exp_ovf) else begin
      fails++;
      $error("FAIL ovf cyc=%0d got %b expected %b", cyc, ovf, exp_ovf);
    end
    tests++;
    assert (dp === 1'b1) else begin
      fails++;
      $error("FAIL dp cyc=%0d got %b expected 1", cyc, dp);
    end
    d = an_index(an);
    tests++;
    assert (d >= 0) else begin
      fails++;
      $error("FAIL an_onehot cyc=%0d got %b expected one low bit", cyc, an);
    end
    if (d >= 0) begin
      exp_seg = model_seg(exp_val, d);
      tests++;
      assert (seg === exp_seg) else begin
        fails++;
        $error("FAIL seg cyc=%0d digit=%0d value=%0d got %b expected %b",
               cyc, d, exp_val, seg, exp_seg);
      end
    end
  endtask

  task automatic tick();
    int tmp;
    @(posedge clk);
    #1;
    cyc++;
    while (q_cyc.size() > 0 && q_cyc[0] <= cyc) begin
      tmp     = q_cyc.pop_front();
      exp_val = q_val.pop_front();
    end
    check_outputs();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clear_model();
    exp_val   = 0;
    busy_end  = -100;
    done_at   = -100;
    pend_start = -100;
    pend_open = 1'b0;
    q_cyc.delete();
    q_val.delete();
  endtask

  // Strobe one value; model: busy for 15 cycles from acceptance, display 16 edges
  // after acceptance; strobes while busy start at the current DONE, last one wins.
  task automatic send(input int v);
    int e;
    int dstart;
    e = cyc + 1;
    if (e > busy_end + 1) begin
      busy_end = e + 14;
      done_at  = e + 15;
      pend_open = 1'b0;
      q_cyc.push_back(e + 16);
      q_val.push_back(v);
    end else if (pend_open && e <= pend_start) begin
      q_val[q_val.size() - 1] = v;
    end else begin
      dstart     = done_at;
      busy_end   = dstart + 14;
      done_at    = dstart + 15;
      pend_start = dstart;
      pend_open  = 1'b1;
      q_cyc.push_back(dstart + 16);
      q_val.push_back(v);
    end
    count_in    = 14'(v);
    count_valid = 1'b1;
    tick();
    count_valid = 1'b0;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    clear_model();
    ticks(n);
    reset = 1'b0;
  endtask

  initial begin
    logic [3:0] prev_an;
    int run_len;
    int ntrans;
    int v;

    reset       = 1'b1;
    count_in    = '0;
    count_valid = 1'b0;

    // Reset for 3 cycles, then watch the scan order and dwell time
    do_reset(3);
    tick();
    tests++;
    assert (an === 4'b1110) else begin
      fails++;
      $error("FAIL scan_first got %b expected 1110", an);
    end
    prev_an = an;
    run_len = 1;
    ntrans  = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (an !== prev_an) begin
        tests++;
        assert (an === {prev_an[2:0], prev_an[3]}) else begin
          fails++;
          $error("FAIL scan_order got %b expected %b", an, {prev_an[2:0], prev_an[3]});
        end
        if (ntrans > 0) begin
          tests++;
          assert (run_len == 4) else begin
            fails++;
            $error("FAIL scan_dwell got %0d expected 4", run_len);
          end
        end
        ntrans++;
        run_len = 1;
        prev_an = an;
      end else begin
        run_len++;
      end
    end
    tests++;
    assert (ntrans >= 4) else begin
      fails++;
      $error("FAIL scan_transitions got %0d expected >=4", ntrans);
    end

    // Basic conversion and latency
    send(1234);
    ticks(24);

    // Largest legal value, then out of range
    send(9999);
    ticks(20);
    send(10000);
    ticks(24);

    // Pending overwrite: 77 superseded by 305
    send(5);
    ticks(2);
    send(77);
    ticks(2);
    send(305);
    ticks(36);

    // Reset during conversion aborts it
    send(42);
    ticks(5);
    do_reset(1);
    ticks(24);

    // Strobe coincident with reset is dropped
    reset       = 1'b1;
    count_valid = 1'b1;
    count_in    = 14'd777;
    clear_model();
    tick();
    reset       = 1'b0;
    count_valid = 1'b0;
    ticks(24);

    // Random values at random spacing, including strobes during busy and DONE
    for (int n = 0; n < 24; n++) begin
      if ($urandom_range(0, 2) == 0) v = int'($urandom_range(0, 99));
      else v = int'($urandom_range(0, 16383));
      send(v);
      ticks(int'($urandom_range(0, 20)));
    end
    ticks(40);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
